// File: rtl/gcm_pkg.sv
// Shared constants and types for the GCM block feeder and its byte packer.
package gcm_pkg;

  localparam int BLK_W         = 128;
  localparam int BYTES_PER_BLK = BLK_W / 8;

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, DONE} feeder_state_t;

  typedef logic [63:0] gcm_len_t;

  // Width of a word-slot index; a single-word block still needs one bit.
  function automatic int fill_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/gcm_block_feeder_if.sv
// Byte-stream channel into the GCM block feeder (AAD section, then plaintext section).
interface gcm_block_feeder_if #(
  parameter int WORD_W = 32
) ();

  logic [WORD_W-1:0]   s_data;
  logic [WORD_W/8-1:0] s_keep;
  logic                s_aad;
  logic                s_last;
  logic                s_valid;
  logic                s_ready;

  modport master (
    output s_data, s_keep, s_aad, s_last, s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data, s_keep, s_aad, s_last, s_valid,
    output s_ready
  );

endinterface

// File: rtl/gcm_byte_packer.sv
// Merges one stream word into the block accumulator at the current word slot, zeroing unkept bytes.
// GCM_FEEDER_BYTESWAP_EN selects the byte-reversed layout; otherwise stream byte 0 lands in the MSBs.
module gcm_byte_packer
  import gcm_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int FILL_W = 2
) (
  input  logic [BLK_W-1:0]    i_acc,
  input  logic [FILL_W-1:0]   i_fill,
  input  logic [WORD_W-1:0]   i_data,
  input  logic [WORD_W/8-1:0] i_keep,
  output logic [BLK_W-1:0]    o_acc
);

  localparam int BPW = WORD_W / 8;

  always_comb begin
    o_acc = i_acc;
    for (int j = 0; j < BPW; j++) begin
`ifdef GCM_FEEDER_BYTESWAP_EN
      o_acc[8*(int'(i_fill)*BPW + j) +: 8] =
        i_keep[BPW-1-j] ? i_data[WORD_W-1-8*j -: 8] : 8'h00;
`else
      o_acc[BLK_W-1-8*(int'(i_fill)*BPW + j) -: 8] =
        i_keep[BPW-1-j] ? i_data[WORD_W-1-8*j -: 8] : 8'h00;
`endif
    end
  end

endmodule

// File: rtl/gcm_block_feeder.sv
// Upstream stage of gcm_aes: packs AAD/plaintext words into 128-bit blocks, issues them one at a
// time and tracks section bit-lengths. Byte layout is set by GCM_FEEDER_BYTESWAP_EN (see packer).
module gcm_block_feeder
  import gcm_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [127:0]       i_cipher_key,
  input  logic [95:0]        i_iv,
  gcm_block_feeder_if.slave  s,
  output logic [127:0]       o_cipher_key,
  output logic [95:0]        o_iv,
  output logic [BLK_W-1:0]   o_block,
  output logic               o_new_instance,
  output logic               o_pt_instance,
  output logic               o_blk_valid,
  input  logic               i_core_ready,
  output gcm_len_t           o_aad_size,
  output gcm_len_t           o_plain_text_size,
  output logic               o_done
);

  localparam int WORDS  = BLK_W / WORD_W;
  localparam int FILL_W = fill_width(WORDS);

  feeder_state_t     r_state, w_next_state;
  logic [127:0]      r_key;
  logic [95:0]       r_iv;
  logic [BLK_W-1:0]  r_acc, r_block, w_packed;
  logic [FILL_W-1:0] r_fill;
  logic              r_first, r_sec_aad, r_last_pt, r_new_inst, r_pt_inst;
  gcm_len_t          r_aad_size, r_pt_size, w_add_bits;
  logic              w_s_ready, w_accept, w_switch, w_empty, w_close, w_fire, w_done;

  assign w_add_bits = gcm_len_t'($countones(s.s_keep)) << 3;
  assign w_accept   = s.s_valid && w_s_ready;
  // A section change with bytes pending flushes them first; the new word waits a round.
  assign w_switch   = s.s_valid && (r_fill != '0) && (s.s_aad != r_sec_aad);
  assign w_empty    = s.s_last && (s.s_keep == '0) && (r_fill == '0);
  assign w_close    = s.s_last || (r_fill == FILL_W'(WORDS - 1));
  assign w_fire     = (r_state == ISSUE) && i_core_ready;

  gcm_byte_packer #(
    .WORD_W (WORD_W),
    .FILL_W (FILL_W)
  ) u_packer (
    .i_acc  (r_acc),
    .i_fill (r_fill),
    .i_data (s.s_data),
    .i_keep (s.s_keep),
    .o_acc  (w_packed)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_s_ready    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_next_state = FILL;
      FILL: begin
        w_s_ready = !w_switch;
        if (w_switch) begin
          w_next_state = ISSUE;
        end else if (s.s_valid) begin
          if (w_empty) begin
            if (!s.s_aad) w_next_state = DONE;
          end else if (w_close) begin
            w_next_state = ISSUE;
          end
        end
      end
      ISSUE: if (i_core_ready) w_next_state = r_last_pt ? DONE : FILL;
      DONE: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key      <= '0;
      r_iv       <= '0;
      r_acc      <= '0;
      r_block    <= '0;
      r_fill     <= '0;
      r_first    <= 1'b0;
      r_sec_aad  <= 1'b0;
      r_last_pt  <= 1'b0;
      r_new_inst <= 1'b0;
      r_pt_inst  <= 1'b0;
      r_aad_size <= '0;
      r_pt_size  <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_key      <= i_cipher_key;
          r_iv       <= i_iv;
          r_aad_size <= '0;
          r_pt_size  <= '0;
          r_first    <= 1'b1;
          r_fill     <= '0;
          r_acc      <= '0;
          r_last_pt  <= 1'b0;
        end
        FILL: begin
          if (w_switch) begin
            r_fill    <= '0;
            r_last_pt <= 1'b0;
          end else if (w_accept) begin
            r_acc     <= w_packed;
            r_sec_aad <= s.s_aad;
            if (s.s_aad) r_aad_size <= r_aad_size + w_add_bits;
            else         r_pt_size  <= r_pt_size + w_add_bits;
            if (!w_empty) begin
              if (w_close) begin
                r_fill    <= '0;
                r_last_pt <= s.s_last && !s.s_aad;
              end else begin
                r_fill <= r_fill + 1'b1;
              end
            end
          end
        end
        ISSUE: if (i_core_ready) begin
          r_block    <= r_acc;
          r_new_inst <= r_first;
          r_pt_inst  <= !r_sec_aad;
          r_first    <= 1'b0;
          r_acc      <= '0;
        end
        default: ;
      endcase
    end
  end

  // The issued block and its flags show combinationally on the strobe cycle, then stay registered.
  assign o_block           = w_fire ? r_acc : r_block;
  assign o_new_instance    = w_fire ? r_first : r_new_inst;
  assign o_pt_instance     = w_fire ? !r_sec_aad : r_pt_inst;
  assign o_blk_valid       = w_fire;
  assign o_done            = w_done;
  assign o_cipher_key      = r_key;
  assign o_iv              = r_iv;
  assign o_aad_size        = r_aad_size;
  assign o_plain_text_size = r_pt_size;
  assign s.s_ready         = w_s_ready;

endmodule

// File: tb/tb_gcm_block_feeder.sv
// Self-checking bench for gcm_block_feeder: directed sessions plus random-length sessions
// checked against a byte-queue model of block assembly, padding, ordering and bit-lengths.
module tb_gcm_block_feeder;

  localparam int WORD_W = 32;
  localparam int BPW    = WORD_W / 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [127:0] i_cipher_key;
  logic [95:0]  i_iv;
  logic         i_core_ready;
  logic [127:0] o_cipher_key;
  logic [95:0]  o_iv;
  logic [127:0] o_block;
  logic         o_new_instance, o_pt_instance, o_blk_valid, o_done;
  logic [63:0]  o_aad_size, o_plain_text_size;

  gcm_block_feeder_if #(.WORD_W(WORD_W)) ifc ();

  gcm_block_feeder #(.WORD_W(WORD_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_cipher_key      (i_cipher_key),
    .i_iv              (i_iv),
    .s                 (ifc),
    .o_cipher_key      (o_cipher_key),
    .o_iv              (o_iv),
    .o_block           (o_block),
    .o_new_instance    (o_new_instance),
    .o_pt_instance     (o_pt_instance),
    .o_blk_valid       (o_blk_valid),
    .i_core_ready      (i_core_ready),
    .o_aad_size        (o_aad_size),
    .o_plain_text_size (o_plain_text_size),
    .o_done            (o_done)
  );

  always #5 clk = ~clk;

  int cmpCount = 0;
  int errCount = 0;
  int coreMode = 1;
  int doneCount = 0;
  int issueBase, doneBase;
  logic [7:0]   aadQ[$];
  logic [7:0]   ptQ[$];
  logic [127:0] obsBlk[$];
  logic         obsNew[$];
  logic         obsPt[$];
  logic [63:0]  doneAad, donePt;
  logic [127:0] prevBlock;
  logic [127:0] expVec;

  // Core readiness: 0 holds low, 1 holds high, anything else toggles randomly.
  always begin
    @(posedge clk);
    #1;
    case (coreMode)
      0:       i_core_ready = 1'b0;
      1:       i_core_ready = 1'b1;
      default: i_core_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (o_blk_valid === 1'b1) begin
        obsBlk.push_back(o_block);
        obsNew.push_back(o_new_instance);
        obsPt.push_back(o_pt_instance);
      end
      if (o_done === 1'b1) begin
        doneCount++;
        doneAad = o_aad_size;
        donePt  = o_plain_text_size;
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [WORD_W-1:0] data, input logic [BPW-1:0] keep,
                               input logic aad, input logic last);
    bit accepted;
    accepted    = 1'b0;
    ifc.s_data  = data;
    ifc.s_keep  = keep;
    ifc.s_aad   = aad;
    ifc.s_last  = last;
    ifc.s_valid = 1'b1;
    for (int c = 0; c < 400 && !accepted; c++) begin
      @(negedge clk);
      if (ifc.s_ready === 1'b1) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end
    end
    ifc.s_valid = 1'b0;
    ifc.s_last  = 1'b0;
    checkOutput("accept", 128'(accepted), 128'(1'b1));
  endtask

  task automatic sendSection(input bit isAad);
    logic [7:0]        q[$];
    int                n, nw;
    logic [WORD_W-1:0] d;
    logic [BPW-1:0]    k;
    if (isAad) q = aadQ;
    else       q = ptQ;
    n  = q.size();
    nw = (n == 0) ? 1 : (n + BPW - 1) / BPW;
    for (int w = 0; w < nw; w++) begin
      d = $urandom;
      k = '0;
      for (int j = 0; j < BPW; j++) begin
        if (w*BPW + j < n) begin
          d[WORD_W-1-8*j -: 8] = q[w*BPW + j];
          k[BPW-1-j]           = 1'b1;
        end
      end
      applyStimulus(d, k, isAad, (w == nw - 1));
    end
  endtask

  task automatic startSession(input logic [127:0] key, input logic [95:0] iv);
    issueBase    = obsBlk.size();
    doneBase     = doneCount;
    i_cipher_key = key;
    i_iv         = iv;
    i_start      = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic fillRandom(input int aadLen, input int ptLen);
    aadQ.delete();
    ptQ.delete();
    for (int i = 0; i < aadLen; i++) aadQ.push_back(8'($urandom));
    for (int i = 0; i < ptLen; i++)  ptQ.push_back(8'($urandom));
  endtask

  // Block b of a section: 16 consecutive stream bytes, zero beyond the section end.
  function automatic logic [127:0] modelBlock(input bit isAad, input int b);
    logic [127:0] blk;
    logic [7:0]   v;
    int           n;
    blk = '0;
    n   = isAad ? aadQ.size() : ptQ.size();
    for (int i = 0; i < 16; i++) begin
      if (b*16 + i < n) begin
        v = isAad ? aadQ[b*16 + i] : ptQ[b*16 + i];
`ifdef GCM_FEEDER_BYTESWAP_EN
        blk[8*i +: 8] = v;
`else
        blk[127-8*i -: 8] = v;
`endif
      end
    end
    return blk;
  endfunction

  task automatic finishSession(input string tag, input logic [127:0] expKey, input logic [95:0] expIv);
    int           nA, nP, nExp, got;
    bit           seen, isAad;
    logic [127:0] eb;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (doneCount > doneBase) seen = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput($sformatf("%s.done", tag), 128'(doneCount - doneBase), 128'(1));
    nA   = (aadQ.size() + 15) / 16;
    nP   = (ptQ.size() + 15) / 16;
    nExp = nA + nP;
    got  = obsBlk.size() - issueBase;
    checkOutput($sformatf("%s.issues", tag), 128'(got), 128'(nExp));
    for (int i = 0; i < nExp && i < got; i++) begin
      isAad = (i < nA);
      eb    = modelBlock(isAad, isAad ? i : i - nA);
      checkOutput($sformatf("%s.blk%0d", tag, i), obsBlk[issueBase+i], eb);
      checkOutput($sformatf("%s.new%0d", tag, i), 128'(obsNew[issueBase+i]), 128'(i == 0));
      checkOutput($sformatf("%s.pt%0d", tag, i), 128'(obsPt[issueBase+i]), 128'(!isAad));
      prevBlock = eb;
    end
    checkOutput($sformatf("%s.aadSize", tag), 128'(doneAad), 128'(aadQ.size() * 8));
    checkOutput($sformatf("%s.ptSize", tag), 128'(donePt), 128'(ptQ.size() * 8));
    checkOutput($sformatf("%s.key", tag), o_cipher_key, expKey);
    checkOutput($sformatf("%s.iv", tag), 128'(o_iv), 128'(expIv));
  endtask

  initial begin
    logic [127:0] vecA, vecP, keyA, keyB;
    logic [95:0]  ivA;

    rst          = 1'b1;
    i_start      = 1'b0;
    i_cipher_key = '0;
    i_iv         = '0;
    ifc.s_data   = '0;
    ifc.s_keep   = '0;
    ifc.s_aad    = 1'b0;
    ifc.s_last   = 1'b0;
    ifc.s_valid  = 1'b0;
    prevBlock    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.blkValid", 128'(o_blk_valid), 128'(0));
    checkOutput("rst.done", 128'(o_done), 128'(0));
    checkOutput("rst.block", o_block, 128'(0));
    checkOutput("rst.aadSize", 128'(o_aad_size), 128'(0));
    checkOutput("rst.ptSize", 128'(o_plain_text_size), 128'(0));
    checkOutput("rst.key", o_cipher_key, 128'(0));
    checkOutput("rst.sReady", 128'(ifc.s_ready), 128'(0));
    checkOutput("rst.flags", 128'({o_new_instance, o_pt_instance}), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] known-answer session");
    vecA = 128'h3AD77BB4_0D7A3660_A89ECAF3_2466EF97;
    vecP = 128'hD9313225_F88406E5_A55909C5_AFF5269A;
    aadQ.delete();
    ptQ.delete();
    for (int i = 0; i < 16; i++) begin
      aadQ.push_back(vecA[127-8*i -: 8]);
      ptQ.push_back(vecP[127-8*i -: 8]);
    end
`ifdef GCM_FEEDER_BYTESWAP_EN
    expVec = 128'h97EF6624_F3CA9EA8_60367A0D_B47BD73A;
`else
    expVec = 128'h3AD77BB4_0D7A3660_A89ECAF3_2466EF97;
`endif
    keyA = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    ivA  = 96'hCAFEBABE_FACEDBAD_DECAF888;
    startSession(keyA, ivA);
    sendSection(1'b1);
    sendSection(1'b0);
    finishSession("vec", keyA, ivA);
    if (obsBlk.size() > issueBase) checkOutput("vec.const", obsBlk[issueBase], expVec);

    $display("[TB] plaintext-only 20 bytes");
    coreMode = 2;
    fillRandom(0, 20);
    startSession(keyA, ivA);
    sendSection(1'b0);
    finishSession("pt20", keyA, ivA);

    $display("[TB] empty plaintext after 16 AAD bytes");
    fillRandom(16, 0);
    startSession(keyA, ivA);
    sendSection(1'b1);
    sendSection(1'b0);
    finishSession("emptyPt", keyA, ivA);

    $display("[TB] core stall at issue");
    coreMode = 0;
    fillRandom(16, 8);
    startSession(keyA, ivA);
    sendSection(1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("stall.sReady", 128'(ifc.s_ready), 128'(0));
      checkOutput("stall.hold", o_block, prevBlock);
      checkOutput("stall.noStrobe", 128'(o_blk_valid), 128'(0));
    end
    coreMode = 1;
    @(negedge clk);
    checkOutput("stall.strobe", 128'(o_blk_valid), 128'(1));
    checkOutput("stall.block", o_block, modelBlock(1'b1, 0));
    @(posedge clk);
    #1;
    sendSection(1'b0);
    finishSession("stall", keyA, ivA);

    $display("[TB] start pulse during fill");
    coreMode = 2;
    keyB = {$urandom, $urandom, $urandom, $urandom};
    fillRandom(8, 12);
    startSession(keyA, ivA);
    i_cipher_key = keyB;
    i_start      = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    sendSection(1'b1);
    sendSection(1'b0);
    finishSession("ignStart", keyA, ivA);

    $display("[TB] reset mid-session");
    fillRandom(16, 0);
    startSession(keyB, ivA);
    applyStimulus(WORD_W'($urandom), '1, 1'b1, 1'b0);
    applyStimulus(WORD_W'($urandom), '1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRst.key", o_cipher_key, 128'(0));
    checkOutput("midRst.aadSize", 128'(o_aad_size), 128'(0));
    checkOutput("midRst.block", o_block, 128'(0));
    checkOutput("midRst.sReady", 128'(ifc.s_ready), 128'(0));
    checkOutput("midRst.blkValid", 128'(o_blk_valid), 128'(0));
    @(posedge clk);
    #1;
    rst       = 1'b0;
    prevBlock = '0;
    fillRandom(5, 33);
    startSession(keyB, ivA);
    sendSection(1'b1);
    sendSection(1'b0);
    finishSession("postRst", keyB, ivA);

    $display("[TB] random sessions");
    for (int sIdx = 0; sIdx < 5; sIdx++) begin
      keyB = {$urandom, $urandom, $urandom, $urandom};
      fillRandom($urandom_range(0, 40), $urandom_range(0, 40));
      startSession(keyB, ivA);
      if (aadQ.size() > 0) sendSection(1'b1);
      sendSection(1'b0);
      finishSession($sformatf("rand%0d", sIdx), keyB, ivA);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/gcm_block_feeder.md
Name: gcm_block_feeder

Overview:
- Upstream stage of gcm_aes.
- Accepts a 32-bit byte stream carrying the AAD section, then the plaintext section, for one GCM session.
- Assembles 128-bit blocks, zero-pads the final partial block of each section, and applies the byte ordering gcm_aes expects.
- Issues blocks one at a time with the instance strobes, waits for the core between blocks, and accumulates the 64-bit bit-lengths for i_aad_size / i_plain_text_size.

Parameters:
- WORD_W, 32, input word width; must divide 128 (32, 64 or 128 legal).
- BLK_W, 128, block width; fixed, parameterised only for the package constant.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse; latches i_cipher_key and i_iv, opens a session (honoured only in IDLE).
- i_cipher_key  in  128  session key.
- i_iv  in  96  session IV.
- s_data  in  WORD_W  stream word; s_data[WORD_W-1 -: 8] is the earliest byte.
- s_keep  in  WORD_W/8  valid bytes, contiguous from the MSB byte; all-ones except on s_last.
- s_aad  in  1  1 = word belongs to the AAD section, 0 = plaintext.
- s_last  in  1  last word of the current section.
- s_valid  in  1  word valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- o_cipher_key  out  128  latched key.
- o_iv  out  96  latched IV.
- o_block  out  128  block to the core (i_plain_text / i_aad).
- o_new_instance  out  1  high during issue of the session's first block.
- o_pt_instance  out  1  high during issue of plaintext blocks.
- o_blk_valid  out  1  one-cycle issue strobe.
- i_core_ready  in  1  core idle and able to take a block (from o_cp_ready).
- o_aad_size  out  64  AAD bits accepted so far.
- o_plain_text_size  out  64  plaintext bits accepted so far.
- o_done  out  1  one-cycle pulse when the session is complete.

Behaviour:
- Reset: all outputs 0; state IDLE; fill count 0.
- Reset asserted mid-session aborts the session; no further strobes are issued.
- States and transitions:
  - IDLE: s_ready=0; on i_start latch key/IV, clear sizes, set first_flag, go to FILL.
  - FILL: s_ready=1. Each accepted word is placed at byte offset fill*(WORD_W/8), and popcount(s_keep)*8 is added to the size counter selected by s_aad. Go to ISSUE when the block is full or s_last is set; partial bytes are zero.
  - FILL, empty section: s_last with s_keep=0 and fill=0 issues nothing. If s_aad=0 go to DONE, else stay in FILL.
  - ISSUE: s_ready=0; wait for i_core_ready. Then, for one cycle, drive o_blk_valid=1, o_new_instance=first_flag and o_pt_instance=!section_aad, and clear first_flag. Go to FILL, or to DONE if this was the plaintext s_last block.
  - DONE: o_done=1 for one cycle, then IDLE.
- o_block, o_new_instance and o_pt_instance are held from the issue cycle until the next issue.
- Sizes are final and stable from the last issue through o_done, until the next i_start.
- Latency: at least 1 cycle from the accepting handshake of the block-completing word to o_blk_valid.
- Section switch: an s_aad change without a preceding s_last is a protocol error. The partial block is flushed as its original section (same as s_last), then the new section begins.
- AAD after the plaintext section is not supported. i_start outside IDLE is ignored.
- Size counters wrap modulo 2^64.

Optional Feature:
- Macro GCM_FEEDER_BYTESWAP_EN.
- Defined: stream byte k is placed at o_block[8k+7:8k] (byte-reversed, as gcm_aes consumes).
- Undefined: stream byte k is placed at o_block[127-8k -: 8] (natural big-endian).
- Padding and size rules are identical in both modes.

Decomposition:
- Package gcm_pkg: BLK_W; BYTES_PER_BLK=16; state enum feeder_state_t {IDLE, FILL, ISSUE, DONE}; 64-bit length typedef gcm_len_t.
- Sub-module gcm_byte_packer: word-to-block shift/merge with keep masking and the byte-order option. The FSM stays in gcm_block_feeder.

Test Plan:
- AAD 16 bytes 3AD77BB4_0D7A3660_A89ECAF3_2466EF97, then plaintext 16 bytes D9313225_F88406E5_A55909C5_AFF5269A, with BYTESWAP_EN defined -> two issues. The first has o_new_instance=1, o_pt_instance=0 and o_block=97EF6624_F3CA9EA8_60367A0D_B47BD73A. Finally o_aad_size=128, o_plain_text_size=128, o_done.
- Plaintext only, 20 bytes (s_keep=4'hF on the last word) -> two issues. The second block holds 4 bytes then zeros; o_plain_text_size=160; o_aad_size=0.
- Empty plaintext section (s_aad=0, s_last, s_keep=0) after 16 AAD bytes -> one issue; o_done; o_plain_text_size=0.
- i_core_ready held low for 10 cycles at ISSUE -> s_ready=0 and o_block stable; issue on the cycle i_core_ready rises.
- rst pulsed after 2 words accepted -> all outputs 0 the next cycle; a new i_start session produces correct sizes.
- i_start pulsed during FILL -> ignored; the latched key is unchanged.
